// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Latency: none, wires only.
// Backpressure: none; the requester watches busy/done and re-presents start.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             Cout;

   // requester side: issues operands, observes status and result
   modport master (
      output start, A, B, Cin,
      input  busy, done, sum, Cout
   );

   // adder side: consumes operands, produces status and result
   modport slave (
      input  start, A, B, Cin,
      output busy, done, sum, Cout
   );
endinterface

// File: rtl/serial_adder.sv
// 1-bit full adder cell, reused by the serial adder below.
// Latency: combinational.
// Backpressure: none.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Bit-serial WIDTH-bit adder: one full adder cell, LSB first, carry registered between bits.
// Latency: done pulses WIDTH clocks after start is accepted; one result every WIDTH+1 clocks back-to-back.
// Backpressure: start is accepted only in IDLE or DONE; start during RUN is ignored.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   serial_adder_if.slave  bus
);
   // bit counter only has to reach WIDTH-1; keep it at least one bit wide
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] part_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   full_adder u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // new sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts
   generate
      if (WIDTH == 1) begin : g_narrow
         assign part_nxt = fa_s;
      end else begin : g_wide
         assign part_nxt = {fa_s, part[WIDTH-1:1]};
      end
   endgenerate

   // control FSM and datapath; sum/Cout only move on the final bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         opa    <= '0;
         opb    <= '0;
         part   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  opa    <= bus.A;
                  opb    <= bus.B;
                  carry  <= bus.Cin;
                  part   <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               opa   <= opa >> 1;
               opb   <= opb >> 1;
               carry <= fa_c;
               part  <= part_nxt;
               if (cnt == LAST) begin
                  cnt    <= '0;
                  sum_r  <= part_nxt;
                  cout_r <= fa_c;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= DONE;
               end else begin
                  cnt    <= cnt + 1'b1;
               end
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.Cout = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1 side by side.
// Latency: a transaction-level model predicts busy/done/sum/Cout every cycle.
// Backpressure: start is re-driven by the bench; the model decides acceptance.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) i8 ();
   serial_adder_if #(.WIDTH(1)) i1 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

   // index 0 drives the 8-bit adder, index 1 the 1-bit adder
   logic       st [2];
   logic [7:0] a  [2];
   logic [7:0] b  [2];
   logic       ci [2];

   assign i8.start = st[0];
   assign i8.A     = a[0];
   assign i8.B     = b[0];
   assign i8.Cin   = ci[0];
   assign i1.start = st[1];
   assign i1.A     = a[1][0];
   assign i1.B     = b[1][0];
   assign i1.Cin   = ci[1];

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: an accepted op finishes WIDTH edges later with {Cout,sum} = A+B+Cin
   int                m_cnt  [2] = '{0, 0};
   logic              m_done [2] = '{1'b0, 1'b0};
   longint unsigned   m_pend [2] = '{0, 0};
   longint unsigned   m_sum  [2] = '{0, 0};
   logic              m_cout [2] = '{1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      int w;
      longint unsigned mk;
      for (int d = 0; d < 2; d++) begin
         w  = (d == 0) ? 8 : 1;
         mk = (64'd1 << w) - 64'd1;
         if (rst) begin
            m_cnt[d]  = 0;
            m_done[d] = 1'b0;
            m_sum[d]  = 0;
            m_cout[d] = 1'b0;
         end else begin
            m_done[d] = 1'b0;
            if (m_cnt[d] > 0) begin
               m_cnt[d]--;
               if (m_cnt[d] == 0) begin
                  m_sum[d]  = m_pend[d] & mk;
                  m_cout[d] = m_pend[d][w];
                  m_done[d] = 1'b1;
               end
            end else if (st[d] === 1'b1) begin
               m_pend[d] = (longint'(a[d]) & mk) + (longint'(b[d]) & mk) + longint'(ci[d]);
               m_cnt[d]  = w;
            end
         end
      end
   end

   // every cycle, both adders against the model
   always @(negedge clk) begin
      check("cycle_w8", {i8.busy, i8.done, i8.Cout, i8.sum},
            {m_cnt[0] > 0, m_done[0], m_cout[0], m_sum[0][7:0]});
      check("cycle_w1", {i1.busy, i1.done, i1.Cout, i1.sum},
            {m_cnt[1] > 0, m_done[1], m_cout[1], m_sum[1][0]});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one start pulse on the 8-bit adder; returns edges to done and busy cycles seen
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      output int edges, output int busyn);
      a[0] = av; b[0] = bv; ci[0] = cv; st[0] = 1'b1;
      tick();
      st[0] = 1'b0; st[1] = 1'b0;
      busyn = i8.busy ? 1 : 0;
      edges = 0;
      while (!i8.done && edges < 40) begin
         tick();
         edges++;
         if (i8.busy) busyn++;
      end
      if (!i8.done) check("op8_timeout", 64'd0, 64'd1);
   endtask

   int e, bn, k, n, hold;
   int ed [3];
   logic [8:0] rs [3];
   logic dseen;

   initial begin
      st = '{1'b0, 1'b0}; a = '{8'h0, 8'h0}; b = '{8'h0, 8'h0}; ci = '{1'b0, 1'b0};
      rst = 1'b1;
      #1;
      check("reset_w8", {i8.busy, i8.done, i8.Cout, i8.sum}, 64'd0);
      check("reset_w1", {i1.busy, i1.done, i1.Cout, i1.sum}, 64'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      tick();

      // basic add, latency and busy length; 1-bit adder does 1+1+1 alongside
      a[1] = 8'h1; b[1] = 8'h1; ci[1] = 1'b1; st[1] = 1'b1;
      op8(8'h5A, 8'h3C, 1'b0, e, bn);
      check("t1_latency", e, 8);
      check("t1_busy_cycles", bn, 8);
      check("t1_sum", {i8.Cout, i8.sum}, 9'h096);
      check("t1_model_pin", {m_cout[0], m_sum[0][7:0]}, 9'h096);
      check("t1_w1_sum", {i1.Cout, i1.sum}, 2'b11);

      // new op from DONE: old result held through RUN, updates with done
      a[0] = 8'h01; b[0] = 8'h01; ci[0] = 1'b0; st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      k = 0;
      while (!i8.done && k < 20) begin
         check("t5_hold", i8.sum, 8'h96);
         tick();
         k++;
      end
      check("t5_sum", {i8.Cout, i8.sum}, 9'h002);

      // carry-out corner cases
      tick();
      op8(8'hFF, 8'h01, 1'b0, e, bn);
      check("t2_ff_01", {i8.Cout, i8.sum}, 9'h100);
      op8(8'hFF, 8'h00, 1'b1, e, bn);
      check("t2_ff_00_c", {i8.Cout, i8.sum}, 9'h100);
      op8(8'h00, 8'h00, 1'b1, e, bn);
      check("t2_00_00_c", {i8.Cout, i8.sum}, 9'h001);
      check("t2_model_pin", {m_cout[0], m_sum[0][7:0]}, 9'h001);

      // start held high: accepted only in DONE, period 9, operands sampled only at accept
      tick();
      a[0] = 8'h10; b[0] = 8'h20; ci[0] = 1'b0; st[0] = 1'b1;
      n = 0; k = 0;
      while (n < 3 && k < 100) begin
         tick();
         k++;
         if (i8.done) begin
            ed[n] = k;
            rs[n] = {i8.Cout, i8.sum};
            n++;
         end
         if (n == 1 && k == ed[0] + 3) a[0] = 8'hAA;
      end
      st[0] = 1'b0;
      check("t3_done_count", n, 3);
      check("t3_period_a", ed[1] - ed[0], 9);
      check("t3_period_b", ed[2] - ed[1], 9);
      check("t3_res0", rs[0], 9'h030);
      check("t3_res1_inflight", rs[1], 9'h030);
      check("t3_res2_new_a", rs[2], 9'h0CA);

      // asynchronous reset mid-operation
      tick();
      a[0] = 8'h12; b[0] = 8'h34; st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("t4_async_clear", {i8.busy, i8.done, i8.Cout, i8.sum}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      dseen = 1'b0;
      repeat (10) begin
         tick();
         dseen = dseen | i8.done;
      end
      check("t4_no_done_after_reset", dseen, 1'b0);
      op8(8'h01, 8'h02, 1'b0, e, bn);
      check("t4_after_reset", {i8.Cout, i8.sum}, 9'h003);
      tick();

      // randomized operands on both widths, start held 1..3 edges
      for (int i = 0; i < 1000; i++) begin
         for (int d = 0; d < 2; d++) begin
            a[d]  = 8'($urandom);
            b[d]  = 8'($urandom);
            ci[d] = 1'($urandom_range(0, 1));
            st[d] = 1'b1;
         end
         hold = $urandom_range(1, 3);
         repeat (hold) tick();
         st[0] = 1'b0; st[1] = 1'b0;
         k = 0;
         while ((m_cnt[0] != 0 || m_cnt[1] != 0) && k < 30) begin
            a[0] = 8'($urandom);
            a[1] = 8'($urandom);
            tick();
            k++;
         end
         if (k >= 30) check("rand_timeout", 64'd0, 64'd1);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
